// File: rtl/thermo_decode_pipe.sv
// thermo_decode_pipe: three-stage thermometer-code decoder for a TDC FF column,
// with runtime choice between ones counting and highest 0->1111 edge search.
module thermo_decode_pipe #(
    parameter int NUM_FF    = 64,
    parameter int BITS_DECO = 8,
    parameter int GROUP     = 8
) (
    input  logic                 wClk,
    input  logic                 wRst,
    input  logic                 wValidIn,
    input  logic                 wModeIn,
    input  logic [NUM_FF-1:0]    wDecoIn,
    output logic                 wValidOut,
    output logic [BITS_DECO-1:0] wDecoOut,
    output logic                 wNoEdge,
    output logic                 wAllOnes
);
    localparam int NS = NUM_FF / GROUP;
    localparam int CW = $clog2(GROUP + 1);
    localparam int IW = $clog2(GROUP);

    logic              valid1_d, valid1_q, mode1_d, mode1_q;
    logic [NUM_FF-1:0] data1_d, data1_q;
    logic [NUM_FF+3:0] ext;
    logic              valid2_d, valid2_q, mode2_d, mode2_q;
    logic [CW-1:0]     cnt_d [NS];
    logic [CW-1:0]     cnt_q [NS];
    logic [IW-1:0]     idx_d [NS];
    logic [IW-1:0]     idx_q [NS];
    logic [NS-1:0]     hit_d, hit_q, full_d, full_q;
    logic [BITS_DECO-1:0] sum, pos, deco_d, deco_q;
    logic              any_edge, valid_out_d, valid_out_q;
    logic              no_edge_d, no_edge_q, all_ones_d, all_ones_q;

    assign valid1_d = wValidIn;
    assign mode1_d  = wModeIn;
    assign data1_d  = wDecoIn;
    // Zero padding past the last tap makes windows that run off the end fail naturally.
    assign ext      = {4'b0000, data1_q};
    assign valid2_d = valid1_q;
    assign mode2_d  = mode1_q;

    always_comb begin
        for (int g = 0; g < NS; g++) begin
            cnt_d[g]  = '0;
            idx_d[g]  = '0;
            hit_d[g]  = 1'b0;
            full_d[g] = 1'b1;
            for (int j = 0; j < GROUP; j++) begin
                cnt_d[g]  = cnt_d[g] + CW'(ext[g*GROUP+j]);
                full_d[g] = full_d[g] & ext[g*GROUP+j];
                if (!ext[g*GROUP+j] && (&ext[g*GROUP+j+1 +: 4])) begin
                    hit_d[g] = 1'b1;
                    idx_d[g] = IW'(j);
                end
            end
        end
    end

    always_comb begin
        sum      = '0;
        pos      = '0;
        any_edge = 1'b0;
        for (int g = 0; g < NS; g++) begin
            sum = sum + BITS_DECO'(cnt_q[g]);
            if (hit_q[g]) begin
                any_edge = 1'b1;
                pos      = BITS_DECO'(g * GROUP) + BITS_DECO'(idx_q[g]) + BITS_DECO'(1);
            end
        end
        valid_out_d = valid2_q;
        deco_d      = valid2_q ? (mode2_q ? (any_edge ? pos : '0) : sum) : deco_q;
        no_edge_d   = valid2_q ? (mode2_q & ~any_edge) : no_edge_q;
        all_ones_d  = valid2_q ? (&full_q) : all_ones_q;
    end

    always_ff @(posedge wClk) begin
        if (wRst) begin
            valid1_q    <= 1'b0;
            mode1_q     <= 1'b0;
            data1_q     <= '0;
            valid2_q    <= 1'b0;
            mode2_q     <= 1'b0;
            hit_q       <= '0;
            full_q      <= '0;
            valid_out_q <= 1'b0;
            deco_q      <= '0;
            no_edge_q   <= 1'b0;
            all_ones_q  <= 1'b0;
            for (int g = 0; g < NS; g++) begin
                cnt_q[g] <= '0;
                idx_q[g] <= '0;
            end
        end else begin
            valid1_q    <= valid1_d;
            mode1_q     <= mode1_d;
            data1_q     <= data1_d;
            valid2_q    <= valid2_d;
            mode2_q     <= mode2_d;
            hit_q       <= hit_d;
            full_q      <= full_d;
            valid_out_q <= valid_out_d;
            deco_q      <= deco_d;
            no_edge_q   <= no_edge_d;
            all_ones_q  <= all_ones_d;
            for (int g = 0; g < NS; g++) begin
                cnt_q[g] <= cnt_d[g];
                idx_q[g] <= idx_d[g];
            end
        end
    end

    assign wValidOut = valid_out_q;
    assign wDecoOut  = deco_q;
    assign wNoEdge   = no_edge_q;
    assign wAllOnes  = all_ones_q;
endmodule

// File: tb/tb_thermo_decode_pipe.sv
// tb_thermo_decode_pipe: directed and random samples checked against a
// flat (slice-free) reference decoder through a timestamped scoreboard.
module tb_thermo_decode_pipe;
    logic        wClk = 1'b0, wRst = 1'b1, wValidIn = 1'b0, wModeIn = 1'b0;
    logic [63:0] wDecoIn = '0;
    logic        wValidOut, wNoEdge, wAllOnes;
    logic [7:0]  wDecoOut;
    int          n_cmp = 0, n_bad = 0, cyc = 0;
    bit          en = 1'b0;

    typedef struct {
        int         due;
        logic [7:0] deco;
        logic       ne;
        logic       ao;
    } ent_t;
    ent_t q[$];

    thermo_decode_pipe #(.NUM_FF(64), .BITS_DECO(8), .GROUP(8)) dut (
        .wClk(wClk), .wRst(wRst), .wValidIn(wValidIn), .wModeIn(wModeIn),
        .wDecoIn(wDecoIn), .wValidOut(wValidOut), .wDecoOut(wDecoOut),
        .wNoEdge(wNoEdge), .wAllOnes(wAllOnes)
    );

    always #5 wClk = ~wClk;
    always @(posedge wClk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic ent_t model(input logic m, input logic [63:0] d);
        ent_t e;
        e.due  = 0;
        e.ao   = (d == '1);
        e.ne   = 1'b0;
        e.deco = 8'($countones(d));
        if (m) begin
            e.deco = 0;
            e.ne   = 1'b1;
            for (int i = 59; i >= 0; i--)
                if (d[i] == 1'b0 && d[i+1 +: 4] == 4'hF) begin
                    e.deco = 8'(i + 1);
                    e.ne   = 1'b0;
                    break;
                end
        end
        return e;
    endfunction

    task automatic drive(input logic r, input logic v, input logic m, input logic [63:0] d);
        ent_t e;
        @(posedge wClk);
        #1;
        wRst = r; wValidIn = v; wModeIn = m; wDecoIn = d;
        if (r) begin
            while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
        end else if (v) begin
            e = model(m, d);
            e.due = cyc + 3;
            q.push_back(e);
        end
    endtask

    always @(negedge wClk) begin
        if (en) begin
            while (q.size() > 0 && q[0].due < cyc) begin
                chk("missing_result", 64'(0), 64'(1));
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                chk("valid_out", 64'(wValidOut), 64'(1));
                chk("deco_out", 64'(wDecoOut), 64'(q[0].deco));
                chk("no_edge", 64'(wNoEdge), 64'(q[0].ne));
                chk("all_ones", 64'(wAllOnes), 64'(q[0].ao));
                void'(q.pop_front());
            end else begin
                chk("stray_valid", 64'(wValidOut), 64'(0));
            end
        end
    end

    initial begin
        logic [63:0] d;
        repeat (3) @(posedge wClk);
        @(negedge wClk);
        chk("rst_valid", 64'(wValidOut), 64'(0));
        chk("rst_deco", 64'(wDecoOut), 64'(0));
        chk("rst_noedge", 64'(wNoEdge), 64'(0));
        chk("rst_allones", 64'(wAllOnes), 64'(0));
        en = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 64'hFFFF);
        repeat (5) drive(1'b0, 1'b0, 1'b0, 64'h0);
        drive(1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF00);
        drive(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FF00);
        drive(1'b0, 1'b1, 1'b1, 64'h0000_0000_0000_F5F0);
        drive(1'b0, 1'b1, 1'b0, 64'h0000_0000_0000_F5F0);
        drive(1'b0, 1'b1, 1'b1, 64'h0000_0000_0000_0F00);
        drive(1'b0, 1'b1, 1'b1, 64'h0);
        drive(1'b0, 1'b1, 1'b0, '1);
        drive(1'b0, 1'b1, 1'b1, '1);
        drive(1'b0, 1'b1, 1'b1, 64'hF000_0000_0000_0000);
        drive(1'b0, 1'b1, 1'b1, 64'hE000_0000_0000_0000);
        repeat (4) drive(1'b0, 1'b0, 1'b1, 64'h0);
        for (int k = 0; k < 20; k++) begin
            d = ~64'h0 << $urandom_range(0, 64);
            if ($urandom_range(0, 1) == 1) d = d ^ (64'h1 << $urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) d = {$urandom(), $urandom()};
            drive(k == 10, 1'b1, k[0], d);
        end
        repeat (6) drive(1'b0, 1'b0, 1'b0, {$urandom(), $urandom()});
        chk("scoreboard_drained", 64'(q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
